// File: rtl/router_fifo_pkg.sv
// router_fifo_pkg: shared router widths, header field slices and packet-length helper
package router_fifo_pkg;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 3;
    localparam int LEN_HI = 7;
    localparam int LEN_LO = 2;
    localparam int ADDR_HI = 1;
    localparam int ADDR_LO = 0;
    localparam int MAX_PAYLOAD = 63;
    function automatic logic [CW-1:0] pkt_len(input logic [WIDTH-1:0] hdr);
        return CW'(hdr[LEN_HI:LEN_LO]) + CW'(1);
    endfunction
endpackage

// File: rtl/router_fifo_if.sv
// router_fifo_if: handshake and data bundle between synchronizer/client and one output buffer
interface router_fifo_if;
    import router_fifo_pkg::*;
    logic             soft_reset;
    logic             wr_en;
    logic             rd_en;
    logic             lfd_state;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             pkt_busy;
    modport master (output soft_reset, wr_en, rd_en, lfd_state, din, input dout, full, empty, pkt_busy);
    modport slave (input soft_reset, wr_en, rd_en, lfd_state, din, output dout, full, empty, pkt_busy);
endinterface

// File: rtl/router_fifo.sv
// router_fifo: one output-channel packet buffer with header markers and drain counter
module router_fifo
    import router_fifo_pkg::*;
(
    input logic          clk,
    input logic          rst,
    router_fifo_if.slave bus
);
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH:0]   rd_entry;
    logic             full, empty, do_wr, do_rd;

    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_wr    = bus.wr_en && !full;
    assign do_rd    = bus.rd_en && !empty;
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    // next-state for pointers, read data and the remaining-bytes counter
    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        dout_d   = do_rd ? rd_entry[WIDTH-1:0] : dout_q;
        cnt_d    = !do_rd ? cnt_q :
                   rd_entry[WIDTH] ? pkt_len(rd_entry[WIDTH-1:0]) :
                   (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    // state registers; hard and soft reset both flush and discard same-cycle traffic
    always_ff @(posedge clk) begin
        if (rst || bus.soft_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    // register file; stale contents are harmless because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.din};
    end

    assign bus.dout     = dout_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.pkt_busy = cnt_q != '0;
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: randomized and directed checks of router_fifo against a queue model
module tb_router_fifo;
    logic clk = 0;
    logic rst = 1;
    router_fifo_if bus ();
    router_fifo dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [8:0] q[$];
    logic [7:0] exp_dout = 0;
    int exp_cnt = 0;
    int checks = 0;
    int errors = 0;

    task automatic step(input logic w, input logic r, input logic l, input logic s, input logic [7:0] d);
        logic [8:0] e;
        logic mf, me;
        mf = q.size() == 16;
        me = q.size() == 0;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.lfd_state = l;
        bus.soft_reset = s;
        bus.din = d;
        if (s) begin
            q.delete();
            exp_dout = 0;
            exp_cnt = 0;
        end else begin
            if (r && !me) begin
                e = q.pop_front();
                exp_dout = e[7:0];
                exp_cnt = e[8] ? int'(e[7:2]) + 1 : (exp_cnt > 0 ? exp_cnt - 1 : 0);
            end
            if (w && !mf) q.push_back({l, d});
        end
        @(posedge clk);
        #1;
        bus.wr_en = 0;
        bus.rd_en = 0;
        bus.lfd_state = 0;
        bus.soft_reset = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        exp_dout = 0;
        exp_cnt = 0;
        checks += 4;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", bus.full); end
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", bus.dout); end
        if (bus.pkt_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.pkt_busy); end
    endtask

    task automatic test_single_packet();
        logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h2F};
        logic busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) step(1, 0, i == 0, 0, pkt[i]);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 8'h00);
            checks += 2;
            if (bus.dout !== pkt[i]) begin errors++; $display("FAIL pkt_dout[%0d] got=%h want=%h", i, bus.dout, pkt[i]); end
            if (bus.pkt_busy !== busy[i]) begin errors++; $display("FAIL pkt_busy[%0d] got=%b want=%b", i, bus.pkt_busy, busy[i]); end
        end
        checks++;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL pkt_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i <= 16; i++) begin
            step(1, 0, 0, 0, 8'(i));
            checks++;
            if (bus.full !== (i >= 15)) begin errors++; $display("FAIL fill_full[%0d] got=%b want=%b", i, bus.full, i >= 15); end
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 8'h00);
            checks++;
            if (bus.dout !== 8'(i)) begin errors++; $display("FAIL fill_dout[%0d] got=%h want=%h", i, bus.dout, 8'(i)); end
        end
        checks += 2;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL fill_empty got=%b want=1", bus.empty); end
        if (bus.dout !== 8'h0F) begin errors++; $display("FAIL fill_last got=%h want=0f", bus.dout); end
    endtask

    task automatic test_full_rw();
        logic [7:0] first;
        first = 8'($urandom);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, i == 0 ? first : 8'($urandom));
        step(1, 1, 0, 0, 8'hAA);
        checks += 2;
        if (bus.full !== 1'b0) begin errors++; $display("FAIL frw_full got=%b want=0", bus.full); end
        if (bus.dout !== first) begin errors++; $display("FAIL frw_dout got=%h want=%h", bus.dout, first); end
        step(1, 0, 0, 0, 8'hAA);
        checks++;
        if (bus.full !== 1'b1) begin errors++; $display("FAIL frw_refill got=%b want=1", bus.full); end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 8'h00);
            checks++;
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL frw_drain[%0d] got=%h want=%h", i, bus.dout, exp_dout); end
        end
        checks += 2;
        if (bus.dout !== 8'hAA) begin errors++; $display("FAIL frw_last got=%h want=aa", bus.dout); end
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL frw_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            step(1, 0, ($urandom_range(0, 3) == 0), 0, 8'($urandom));
            checks++;
            if ({bus.empty, bus.full} !== 2'b00) begin errors++; $display("FAIL wrap_flags[%0d] got=%b want=00", i, {bus.empty, bus.full}); end
            step(0, 1, 0, 0, 8'h00);
            checks++;
            if ({bus.dout, bus.empty, bus.full, bus.pkt_busy} !== {exp_dout, 1'b1, 1'b0, exp_cnt != 0}) begin
                errors++;
                $display("FAIL wrap_read[%0d] got=%h/%b%b%b want=%h/10%b", i, bus.dout, bus.empty, bus.full, bus.pkt_busy, exp_dout, exp_cnt != 0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0, 8'($urandom));
            checks++;
            if ({bus.dout, bus.empty, bus.full, bus.pkt_busy} !== {exp_dout, q.size() == 0, q.size() == 16, exp_cnt != 0}) begin
                errors++;
                $display("FAIL rand[%0d] got=%h/%b%b%b want=%h/%b%b%b", i, bus.dout, bus.empty, bus.full, bus.pkt_busy,
                         exp_dout, q.size() == 0, q.size() == 16, exp_cnt != 0);
            end
        end
    endtask

    task automatic test_soft_reset();
        step(0, 0, 0, 1, 8'h00);
        step(1, 0, 1, 0, 8'h14);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'($urandom));
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        checks++;
        if (bus.pkt_busy !== 1'b1) begin errors++; $display("FAIL sr_busy_before got=%b want=1", bus.pkt_busy); end
        step(1, 0, 0, 1, 8'h5A);
        checks += 3;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL sr_empty got=%b want=1", bus.empty); end
        if (bus.pkt_busy !== 1'b0) begin errors++; $display("FAIL sr_busy got=%b want=0", bus.pkt_busy); end
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL sr_dout got=%h want=00", bus.dout); end
        step(0, 1, 0, 0, 8'h00);
        checks += 2;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL sr_discard_empty got=%b want=1", bus.empty); end
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL sr_discard_dout got=%h want=00", bus.dout); end
    endtask

    initial begin
        bus.wr_en = 0;
        bus.rd_en = 0;
        bus.lfd_state = 0;
        bus.soft_reset = 0;
        bus.din = 0;
        test_reset();
        test_single_packet();
        test_fill_overflow();
        test_full_rw();
        test_wrap();
        test_soft_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
